// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: operands are accepted over a valid/ready handshake, added LSB-first
// through one full-adder slice (one bit per clock), and {cout,sum} is returned over valid/ready.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high;
// in_ready and out_valid are decoded from state only, so they never depend on same-cycle inputs.
module serial_adder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_a_sh;
  logic [N-1:0]   r_b_sh;
  logic [N-1:0]   r_sum_sh;
  logic [N-1:0]   r_sum;
  logic           r_carry;
  logic           r_cout;
  logic [CW-1:0]  r_cnt;
  logic           w_s;
  logic           w_carry_next;
  logic           w_last;
  logic [N-1:0]   w_sum_next;
  logic           w_unused;

  // One-bit full-adder slice on the current LSBs and the registered carry.
  assign w_s          = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_carry_next = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
  assign w_last       = (r_cnt == CW'(N - 1));
  assign w_unused     = r_sum_sh[0];

  generate
    if (N == 1) begin : g_one
      assign w_sum_next = w_s;
    end else begin : g_many
      assign w_sum_next = {w_s, r_sum_sh[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_carry  <= w_carry_next;
          r_sum_sh <= w_sum_next;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          // Counter saturates at N-1; the result registers load only on the final slice.
          if (w_last) begin
            r_sum  <= w_sum_next;
            r_cout <= w_carry_next;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an N=8 instance checked every cycle against a
// transaction-level model, plus an N=1 instance swept exhaustively.
module tb_serial_adder;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [N-1:0] a, b, sum;
  logic [1:0]   dbg_state;

  logic         u1_in_valid, u1_in_ready, u1_cin, u1_out_valid, u1_out_ready, u1_cout, u1_busy;
  logic [0:0]   u1_a, u1_b, u1_sum;
  logic [1:0]   u1_dbg_state;

  int total = 0;
  int bad   = 0;

  serial_adder #(.N(N)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy),
    .dbg_state(dbg_state)
  );

  serial_adder #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(u1_in_valid), .in_ready(u1_in_ready), .a(u1_a), .b(u1_b),
    .cin(u1_cin), .out_valid(u1_out_valid), .out_ready(u1_out_ready), .sum(u1_sum),
    .cout(u1_cout), .busy(u1_busy), .dbg_state(u1_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model + scoreboard ----------------
  // Transaction view: an accepted operand set yields a+b+cin after N cycles,
  // held until the consumer takes it; reset drops everything in flight.
  logic [N:0] exp_q[$];
  int         m_mode;   // 0 waiting for operands, 1 computing, 2 holding result
  int         m_left;
  logic [N:0] m_res;
  logic [N:0] m_tmp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      m_left = 0;
      m_res  = '0;
      exp_q.delete();
    end else begin
      case (m_mode)
        0: if (in_valid) begin
          m_tmp = a + b + cin;
          exp_q.push_back(m_tmp);
          m_left = N;
          m_mode = 1;
        end
        1: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_res  = exp_q.pop_front();
            m_mode = 2;
          end
        end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("cyc_in_ready", 32'(in_ready), 32'(m_mode == 0));
      check("cyc_out_valid", 32'(out_valid), 32'(m_mode == 2));
      check("cyc_busy", 32'(busy), 32'(m_mode != 0));
      check("cyc_result", 32'({cout, sum}), 32'(m_res));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tc);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   lat;
    time  t_prev, t_now;
    logic [N-1:0] ra, rb;
    logic rc;
    int   e1;

    rst = 1'b1; in_valid = 0; a = '0; b = '0; cin = 0; out_ready = 0;
    u1_in_valid = 0; u1_a = '0; u1_b = '0; u1_cin = 0; u1_out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_cout", 32'(cout), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // 1: basic add and latency
    send(8'h5A, 8'h3C, 1'b0);
    wait_out(lat);
    check("t1_latency", 32'(lat), 32'd8);
    check("t1_result", 32'({cout, sum}), 32'h096);
    check("t1_model_pin", 32'(m_res), 32'h096);
    release_out();

    // 2: carry-out cases
    send(8'hFF, 8'h01, 1'b0);
    wait_out(lat);
    check("t2a_result", 32'({cout, sum}), 32'h100);
    release_out();
    send(8'hFF, 8'hFF, 1'b1);
    wait_out(lat);
    check("t2b_result", 32'({cout, sum}), 32'h1FF);
    check("t2b_model_pin", 32'(m_res), 32'h1FF);
    release_out();

    // 3: backpressure in DONE with noisy inputs
    send(8'h12, 8'h34, 1'b1);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("t3_hold_valid", 32'(out_valid), 32'h1);
      check("t3_hold_result", 32'({cout, sum}), 32'h047);
      check("t3_no_ready", 32'(in_ready), 32'h0);
    end
    in_valid = 1'b0;
    release_out();
    check("t3_back_idle", 32'(in_ready), 32'h1);
    check("t3_valid_drop", 32'(out_valid), 32'h0);

    // 4: asynchronous reset in the third RUN cycle
    send(8'h77, 8'h11, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_async_valid", 32'(out_valid), 32'h0);
    check("t4_async_busy", 32'(busy), 32'h0);
    check("t4_async_sum", 32'(sum), 32'h0);
    check("t4_async_cout", 32'(cout), 32'h0);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    send(8'h10, 8'h20, 1'b1);
    wait_out(lat);
    check("t4_after_result", 32'({cout, sum}), 32'h031);
    release_out();

    // 5: in_valid and out_ready tied high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      int k = 0;
      while (!in_ready && k < 50) begin
        @(posedge clk); #1; k++;
      end
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      a = ra; b = rb; cin = rc;
      @(posedge clk);
      t_now = $time;
      #1;
      if (i > 0) check("t5_gap_cycles", 32'((t_now - t_prev) / 10), 32'd10);
      t_prev = t_now;
      wait_out(lat);
      check("t5_latency", 32'(lat), 32'd8);
      check("t5_result", 32'({cout, sum}), 32'({1'b0, ra} + {1'b0, rb} + {8'b0, rc}));
    end
    in_valid  = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // 6: N=1 instance, exhaustive
    for (int i = 0; i < 8; i++) begin
      u1_a = i[2]; u1_b = i[1]; u1_cin = i[0];
      u1_in_valid = 1'b1;
      @(posedge clk); #1;
      u1_in_valid = 1'b0;
      lat = 0;
      while (!u1_out_valid && lat < 20) begin
        @(posedge clk); #1; lat++;
      end
      e1 = i[2] + i[1] + i[0];
      check("n1_latency", 32'(lat), 32'd1);
      check("n1_result", 32'({u1_cout, u1_sum}), 32'(e1));
      if (i == 7) check("n1_all_ones", 32'({u1_cout, u1_sum}), 32'h3);
      u1_out_ready = 1'b1;
      @(posedge clk); #1;
      u1_out_ready = 1'b0;
      check("n1_idle", 32'(u1_in_ready), 32'h1);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
